timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Sequencing controller for the stopwatch/countdown timer datapath. It turns debounced button pulses into a mode state machine (idle, run, pause, programming, done) and generates the 1 Hz decrement strobe, the preset load strobe and the BCD preset value for the timer counter. It also produces per-digit blank masks that let the four 7-segment displays blink the digit being edited or flash on expiry. It sits between the debouncers and the timer counter/`dec7seg` path.

## Interface
- `TICK_DIV`, 25_000_000: clock cycles per decrement strobe (1 s at MCLK).
- `BLINK_DIV`, 6_250_000: clock cycles per blink half-period.
- `clk` in 1: system clock (MCLK).
- `rst_n` in 1: reset, asynchronous, active-low. One clock domain only.
- `bt_start` in 1: single-cycle start/stop pulse from the debouncer.
- `bt_prog` in 1: single-cycle program/next-digit pulse.
- `bt_inc` in 1: single-cycle increment-selected-digit pulse.
- `cnt_zero` in 1: datapath counter equals 00:00.
- `preset` out 16: preset value, BCD mm:ss; [15:12] is minutes tens and [3:0] is seconds units.
- `load` out 1: one-cycle strobe telling the datapath to load `preset`.
- `dec_en` out 1: one-cycle strobe telling the datapath to decrement one second.
- `blank` out 4: per-digit blank mask; 1 blanks the digit; [3] is DISP1.
- `state` out 3: current FSM state encoding.
- `alarm` out 1: high while in DONE.

## Operation
- States: IDLE, RUN, PAUSE, PROG_MT, PROG_MU, PROG_ST, PROG_SU, DONE.
- IDLE:
  - `bt_prog` goes to PROG_MT.
  - `bt_start` goes to RUN, unless `cnt_zero` is high, in which case the FSM stays in IDLE.
- RUN:
  - `bt_start` goes to PAUSE.
  - `cnt_zero` high goes to DONE.
  - `bt_prog` is ignored.
- PAUSE:
  - `bt_start` goes to RUN.
  - `bt_prog` goes to PROG_MT.
- PROG_MT → PROG_MU → PROG_ST → PROG_SU advance on `bt_prog`. PROG_SU plus `bt_prog` goes to IDLE and pulses `load`.
- `bt_start` is ignored in all PROG states.
- DONE:
  - `bt_start` goes to IDLE and pulses `load`, reloading the preset.
  - `bt_prog` goes to PROG_MT.
- `bt_inc` in a PROG state increments the selected preset digit modulo its limit:
  - MT: 0–9.
  - MU: 0–9.
  - ST: 0–5.
  - SU: 0–9.
  - Wrap: 9→0 (5→0 for ST).
- `bt_inc` is ignored in all other states.
- Simultaneous events:
  - `cnt_zero` beats `bt_start` in RUN.
  - `bt_prog` beats `bt_start` in PAUSE, IDLE and DONE.
  - `bt_inc` together with `bt_prog` applies the increment to the current digit, then advances.
- Tick counter:
  - Cleared on every entry to RUN.
  - Counts only in RUN.
  - `dec_en` pulses when the counter reaches TICK_DIV−1, then the counter wraps to 0.
  - `dec_en` is never asserted while `cnt_zero` is high, or in the cycle the FSM leaves RUN.
- Blink phase:
  - A free-running counter toggles `phase` every BLINK_DIV cycles.
  - In PROG_x, `blank` has only the selected digit's bit equal to `phase`.
  - In DONE, `blank` is {4{phase}}.
  - Otherwise `blank` is 4'b0000.

## Timing
- All outputs are registered.
- A button pulse in cycle N gives the new `state`, `load`, `preset` and `blank` in cycle N+1.
- `load` is exactly one cycle wide. `preset` is stable in the cycle `load` is high.
- First `dec_en` after entering RUN: TICK_DIV cycles after the entering `bt_start` pulse. Spacing between later strobes: TICK_DIV cycles.
- `cnt_zero` high in RUN in cycle N gives `state`=DONE and `alarm`=1 in cycle N+1.
- Reset values:
  - `state`: IDLE.
  - `preset`: 16'h0000.
  - `load`, `dec_en`, `alarm`: 0.
  - `blank`: 4'b0000.
  - Tick and blink counters: 0. `phase`: 0.
- Reset mid-operation, including mid-programming, discards the edited preset. No `load` is issued on reset release.

## Configuration
- `TIMER_CTRL_BLINK_EN` defined: blink counter present, and `blank` behaves as described above.
- Not defined: blink counter removed and `blank` is constant 4'b0000. DONE is then indicated by `alarm` only. All other behaviour is identical.

## Structure
- Shared package/header `timer_pkg`:
  - State encodings: IDLE=0, RUN=1, PAUSE=2, PROG_MT=3, PROG_MU=4, PROG_ST=5, PROG_SU=6, DONE=7.
  - Digit limits (9, 9, 5, 9).
  - Default divider constants.
- One sub-module, `tick_gen` (parameterised modulo-N counter with clear/enable and a terminal-count pulse), instantiated for the second tick and for the blink phase.

## Test plan
Benches use TICK_DIV=4 and BLINK_DIV=2.
- Program 12:34: `bt_prog`; `bt_inc` ×1; `bt_prog`; `bt_inc` ×2; `bt_prog`; `bt_inc` ×3; `bt_prog`; `bt_inc` ×4; `bt_prog` → `preset`=16'h1234, one-cycle `load`, `state`=IDLE.
- Wrap: PROG_ST plus `bt_inc` ×6 → seconds-tens digit is 0. PROG_MT plus `bt_inc` ×10 → minutes-tens digit is 0.
- Run with `cnt_zero`=0: `bt_start` → `dec_en` pulses every 4 cycles, first at 4 cycles after the pulse. `bt_start` again → PAUSE, no further `dec_en`. Third `bt_start` → RUN, and the next `dec_en` comes 4 cycles later.
- Expiry: `cnt_zero` is raised in RUN in the same cycle as `bt_start` → DONE, `alarm`=1, `blank` toggling 0000/1111 every 2 cycles. `bt_start` → IDLE with one `load` pulse.
- Blink: in PROG_MU, `blank` alternates 0000/0100 every 2 cycles. `bt_start` in PROG_MU → no state change.
- Reset: assert `rst_n`=0 mid-PROG_ST with `preset`=16'h1200 → `preset`=0000, `state`=IDLE, all strobes 0. No `load` after release.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared state encodings, digit limits and divider defaults for timer_ctrl.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    PROG_MT = 3'd3,
    PROG_MU = 3'd4,
    PROG_ST = 3'd5,
    PROG_SU = 3'd6,
    DONE    = 3'd7
  } state_e;

  localparam int unsigned TICK_DIV_DEF  = 25_000_000;
  localparam int unsigned BLINK_DIV_DEF = 6_250_000;

  localparam logic [3:0] LIM_MT = 4'd9;
  localparam logic [3:0] LIM_MU = 4'd9;
  localparam logic [3:0] LIM_ST = 4'd5;
  localparam logic [3:0] LIM_SU = 4'd9;

  function automatic logic is_prog(state_e s);
    return (s == PROG_MT) || (s == PROG_MU) || (s == PROG_ST) || (s == PROG_SU);
  endfunction

  // Digit index in the preset/blank vectors: 3 is minutes tens, 0 is seconds units.
  function automatic logic [1:0] digit_sel(state_e s);
    case (s)
      PROG_MT: return 2'd3;
      PROG_MU: return 2'd2;
      PROG_ST: return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] digit_limit(logic [1:0] idx);
    case (idx)
      2'd3:    return LIM_MT;
      2'd2:    return LIM_MU;
      2'd1:    return LIM_ST;
      default: return LIM_SU;
    endcase
  endfunction

  function automatic logic [3:0] digit_inc(logic [3:0] d, logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Button/status inputs and preset/strobe/display outputs of timer_ctrl.
interface timer_ctrl_if;
  logic        bt_start;
  logic        bt_prog;
  logic        bt_inc;
  logic        cnt_zero;
  logic [15:0] preset;
  logic        load;
  logic        dec_en;
  logic [3:0]  blank;
  logic [2:0]  state;
  logic        alarm;

  modport master (
    input  bt_start, bt_prog, bt_inc, cnt_zero,
    output preset, load, dec_en, blank, state, alarm
  );

  modport slave (
    output bt_start, bt_prog, bt_inc, cnt_zero,
    input  preset, load, dec_en, blank, state, alarm
  );
endinterface

// File: rtl/timer_ctrl_tick_gen.sv
// Modulo-N counter with synchronous clear and count enable; tc_o is a registered
// one-cycle pulse in the cycle the count sits at N-1.
module tick_gen #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;

  // A clear starts a fresh period, so it counts as that period's first cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    tc_d = (clr_i || en_i) && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/timer_ctrl.sv
// Mode FSM, preset editor, 1 Hz strobe and display blanking for the timer datapath.
// Define TIMER_CTRL_BLINK_EN to build the blink counter and per-digit blank masks.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned BLINK_DIV = BLINK_DIV_DEF
) (
  input logic          clk,
  input logic          rst_n,
  timer_ctrl_if.master bus
);

  state_e      state_q, state_d;
  logic [15:0] preset_q, preset_d;
  logic        load_q, load_d;
  logic        alarm_q;
  logic [1:0]  sel;
  logic        enter_run, stay_run, tick_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      preset_q <= 16'h0000;
      load_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      load_q   <= load_d;
      alarm_q  <= (state_d == DONE);
    end
  end

  // The increment lands on the digit of the current state before any advance.
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    load_d   = 1'b0;
    sel      = digit_sel(state_q);

    if (is_prog(state_q) && bus.bt_inc) begin
      preset_d[{sel, 2'b00} +: 4] = digit_inc(preset_q[{sel, 2'b00} +: 4], digit_limit(sel));
    end

    case (state_q)
      IDLE: begin
        if (bus.bt_prog)                        state_d = PROG_MT;
        else if (bus.bt_start && !bus.cnt_zero) state_d = RUN;
      end
      RUN: begin
        if (bus.cnt_zero)      state_d = DONE;
        else if (bus.bt_start) state_d = PAUSE;
      end
      PAUSE: begin
        if (bus.bt_prog)       state_d = PROG_MT;
        else if (bus.bt_start) state_d = RUN;
      end
      PROG_MT: if (bus.bt_prog) state_d = PROG_MU;
      PROG_MU: if (bus.bt_prog) state_d = PROG_ST;
      PROG_ST: if (bus.bt_prog) state_d = PROG_SU;
      PROG_SU: begin
        if (bus.bt_prog) begin
          state_d = IDLE;
          load_d  = 1'b1;
        end
      end
      DONE: begin
        if (bus.bt_prog) begin
          state_d = PROG_MT;
        end else if (bus.bt_start) begin
          state_d = IDLE;
          load_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_run = (state_d == RUN) && (state_q != RUN);
  assign stay_run  = (state_d == RUN) && (state_q == RUN);

  tick_gen #(.N(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (enter_run),
    .en_i  (stay_run),
    .tc_o  (tick_tc)
  );

`ifdef TIMER_CTRL_BLINK_EN
  logic       blink_tc;
  logic       phase_q, phase_d;
  logic [3:0] blank_q, blank_d;

  tick_gen #(.N(BLINK_DIV)) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .en_i  (1'b1),
    .tc_o  (blink_tc)
  );

  // Mask is built from next state and next phase so it lines up with state_q.
  always_comb begin
    phase_d = phase_q ^ blink_tc;
    blank_d = 4'b0000;
    if (is_prog(state_d)) begin
      blank_d[digit_sel(state_d)] = phase_d;
    end else if (state_d == DONE) begin
      blank_d = {4{phase_d}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      blank_q <= 4'b0000;
    end else begin
      phase_q <= phase_d;
      blank_q <= blank_d;
    end
  end

  assign bus.blank = blank_q;
`else
  // BLINK_DIV stays in the parameter list so both builds instantiate alike.
  localparam logic [3:0] BLANK_OFF = (BLINK_DIV > 0) ? 4'b0000 : 4'b0000;
  assign bus.blank = BLANK_OFF;
`endif

  assign bus.state  = state_q;
  assign bus.preset = preset_q;
  assign bus.load   = load_q;
  assign bus.alarm  = alarm_q;
  assign bus.dec_en = tick_tc;

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized and directed bench for timer_ctrl against a cycle-level reference model.
module tb_timer_ctrl;

  localparam int TICK  = 4;
  localparam int BLINK = 2;

  localparam int S_IDLE    = 0;
  localparam int S_RUN     = 1;
  localparam int S_PAUSE   = 2;
  localparam int S_PROG_MT = 3;
  localparam int S_PROG_SU = 6;
  localparam int S_DONE    = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  timer_ctrl_if bus();

  timer_ctrl #(.TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: digit[0] is minutes tens ... digit[3] is seconds units.
  int mState;
  int digit [4];
  bit mLoad;
  int cycle;
  int runStart;
  int blinkCyc;
  int decSeen;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
  endtask

  function automatic int digitModulus(int idx);
    return (idx == 2) ? 6 : 10;
  endfunction

  function automatic logic [15:0] expPreset();
    return {4'(digit[0]), 4'(digit[1]), 4'(digit[2]), 4'(digit[3])};
  endfunction

  function automatic logic expDec();
    return (mState == S_RUN) && (((cycle - runStart + 1) % TICK) == 0);
  endfunction

  function automatic logic [3:0] expBlank();
    logic [3:0] b;
`ifdef TIMER_CTRL_BLINK_EN
    logic ph;
`endif
    b = 4'b0000;
`ifdef TIMER_CTRL_BLINK_EN
    ph = ((blinkCyc / BLINK) % 2) == 1;
    if (mState >= S_PROG_MT && mState <= S_PROG_SU) b[6 - mState] = ph;
    else if (mState == S_DONE) b = {4{ph}};
`endif
    return b;
  endfunction

  task automatic checkAll();
    checkOutput("state",  16'(bus.state),  16'(mState));
    checkOutput("preset", bus.preset,      expPreset());
    checkOutput("load",   16'(bus.load),   16'(mLoad));
    checkOutput("dec_en", 16'(bus.dec_en), 16'(expDec()));
    checkOutput("blank",  16'(bus.blank),  16'(expBlank()));
    checkOutput("alarm",  16'(bus.alarm),  16'(mState == S_DONE));
  endtask

  // Called just after a falling edge; drives one cycle of inputs and checks the result.
  task automatic applyStimulus(input bit s, input bit p, input bit inc, input bit z);
    int nState;
    bit nLoad;
    bus.bt_start = s;
    bus.bt_prog  = p;
    bus.bt_inc   = inc;
    bus.cnt_zero = z;

    nState = mState;
    nLoad  = 1'b0;
    if (mState >= S_PROG_MT && mState <= S_PROG_SU && inc)
      digit[mState - S_PROG_MT] = (digit[mState - S_PROG_MT] + 1) % digitModulus(mState - S_PROG_MT);
    case (mState)
      S_IDLE:  if (p) nState = S_PROG_MT; else if (s && !z) nState = S_RUN;
      S_RUN:   if (z) nState = S_DONE;    else if (s) nState = S_PAUSE;
      S_PAUSE: if (p) nState = S_PROG_MT; else if (s) nState = S_RUN;
      S_PROG_SU: if (p) begin nState = S_IDLE; nLoad = 1'b1; end
      S_DONE: begin
        if (p) nState = S_PROG_MT;
        else if (s) begin nState = S_IDLE; nLoad = 1'b1; end
      end
      default: if (p) nState = mState + 1;
    endcase
    if (nState == S_RUN && mState != S_RUN) runStart = cycle + 1;

    @(posedge clk);
    cycle++;
    blinkCyc++;
    mState = nState;
    mLoad  = nLoad;
    @(negedge clk);
    if (bus.dec_en) decSeen++;
    checkAll();
  endtask

  task automatic resetDut();
    rst_n        = 1'b0;
    bus.bt_start = 1'b0;
    bus.bt_prog  = 1'b0;
    bus.bt_inc   = 1'b0;
    bus.cnt_zero = 1'b0;
    #2;
    mState   = S_IDLE;
    foreach (digit[k]) digit[k] = 0;
    mLoad    = 1'b0;
    cycle    = 0;
    runStart = 0;
    blinkCyc = 0;
    checkAll();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkAll();
  endtask

  initial begin
    bit zr;
    bus.bt_start = 1'b0;
    bus.bt_prog  = 1'b0;
    bus.bt_inc   = 1'b0;
    bus.cnt_zero = 1'b0;
    decSeen      = 0;
    @(negedge clk);
    resetDut();
    checkOutput("rst_preset", bus.preset, 16'h0000);
    checkOutput("rst_state", 16'(bus.state), 16'h0000);
    repeat (3) applyStimulus(0, 0, 0, 0);

    $display("[TB] digit wrap");
    applyStimulus(0, 1, 0, 0);
    repeat (9) applyStimulus(0, 0, 1, 0);
    checkOutput("mt_nine", 16'(bus.preset[15:12]), 16'd9);
    applyStimulus(0, 0, 1, 0);
    checkOutput("mt_wrap", 16'(bus.preset[15:12]), 16'd0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (5) applyStimulus(0, 0, 1, 0);
    checkOutput("st_five", 16'(bus.preset[7:4]), 16'd5);
    applyStimulus(0, 0, 1, 0);
    checkOutput("st_wrap", 16'(bus.preset[7:4]), 16'd0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wrap_load", 16'(bus.load), 16'd1);

    $display("[TB] program 12:34");
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (4) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("p1234_preset", bus.preset, 16'h1234);
    checkOutput("p1234_load", 16'(bus.load), 16'd1);
    checkOutput("p1234_state", 16'(bus.state), 16'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("p1234_load_width", 16'(bus.load), 16'd0);

    $display("[TB] run, pause, resume");
    decSeen = 0;
    applyStimulus(1, 0, 0, 0);
    repeat (12) applyStimulus(0, 0, 0, 0);
    checkOutput("run_dec_count", 16'(decSeen), 16'd3);
    decSeen = 0;
    applyStimulus(1, 0, 0, 0);
    repeat (8) applyStimulus(0, 0, 0, 0);
    checkOutput("pause_dec_count", 16'(decSeen), 16'd0);
    checkOutput("pause_state", 16'(bus.state), 16'd2);
    decSeen = 0;
    applyStimulus(1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);
    checkOutput("resume_early", 16'(decSeen), 16'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("resume_first_dec", 16'(decSeen), 16'd1);

    $display("[TB] expiry");
    applyStimulus(1, 0, 0, 1);
    checkOutput("done_state", 16'(bus.state), 16'd7);
    checkOutput("done_alarm", 16'(bus.alarm), 16'd1);
    repeat (6) applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("done_reload", 16'(bus.load), 16'd1);
    checkOutput("done_to_idle", 16'(bus.state), 16'd0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("idle_zero_start", 16'(bus.state), 16'd0);

    $display("[TB] blink and simultaneous inc/prog");
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (4) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("prog_start_ignored", 16'(bus.state), 16'd4);
    applyStimulus(0, 1, 1, 0);
    checkOutput("inc_then_adv_preset", bus.preset, 16'h1334);
    checkOutput("inc_then_adv_state", 16'(bus.state), 16'd5);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);

    $display("[TB] reset mid-programming");
    resetDut();
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pre_rst_preset", bus.preset, 16'h1200);
    resetDut();
    checkOutput("mid_rst_preset", bus.preset, 16'h0000);
    checkOutput("mid_rst_state", 16'(bus.state), 16'd0);
    repeat (4) applyStimulus(0, 0, 0, 0);

    $display("[TB] random stimulus");
    zr = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 199) == 0) resetDut();
      if ($urandom_range(0, 14) == 0) zr = ~zr;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 2) == 0, zr);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
